// File: rtl/fetch_seq_if.sv
// Handshake and register-transfer strobe bundle between the control unit, datapath and fetch_seq.
// The slave modport is the fetch sequencer's view; master is the surrounding control/datapath view.
interface fetch_seq_if #(
  parameter int unsigned WORDS = 2
);
  logic             start;
  logic             abort;
  logic             MFC;
  logic             PC_read;
  logic             MAR_write;
  logic             MAR_mem_read;
  logic             MEM_RW;
  logic             MEM_EN;
  logic             MDR_mem_write;
  logic             MDR_read;
  logic [WORDS-1:0] IR_write;
  logic             PC_increment;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, MFC,
    input  PC_read, MAR_write, MAR_mem_read, MEM_RW, MEM_EN, MDR_mem_write, MDR_read,
    input  IR_write, PC_increment, busy, done, err
  );

  modport slave (
    input  start, abort, MFC,
    output PC_read, MAR_write, MAR_mem_read, MEM_RW, MEM_EN, MDR_mem_write, MDR_read,
    output IR_write, PC_increment, busy, done, err
  );
endinterface

// File: rtl/fetch_seq.sv
// Multi-word instruction fetch sequencer: one bus read per word, bounded MFC wait with timeout,
// abort back to idle. Outputs are Moore-decoded from the state register.
module fetch_seq #(
  parameter int unsigned WORDS    = 2,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic         clk,
  input logic         reset,
  fetch_seq_if.slave  bus
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(WORDS - 1);
  // Only meaningful when the timeout is enabled.
  localparam logic [WAIT_W-1:0] WaitLast = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StWait,
    StLatch,
    StLoad,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAddr;
          idx_d   = '0;
        end
      end
      StAddr: state_d = StRead;
      StRead: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        // MFC wins over a timeout landing in the same cycle.
        if (bus.MFC) begin
          state_d = StLatch;
        end else if ((WAIT_MAX != 0) && (wait_q == WaitLast)) begin
          state_d = StErr;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLatch: state_d = StLoad;
      StLoad: begin
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StAddr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && bus.abort) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    bus.PC_read       = 1'b0;
    bus.MAR_write     = 1'b0;
    bus.MAR_mem_read  = 1'b0;
    bus.MEM_RW        = 1'b0;
    bus.MEM_EN        = 1'b0;
    bus.MDR_mem_write = 1'b0;
    bus.MDR_read      = 1'b0;
    bus.IR_write      = '0;
    bus.PC_increment  = 1'b0;
    bus.done          = 1'b0;
    bus.err           = 1'b0;
    bus.busy          = (state_q != StIdle);
    case (state_q)
      StAddr: begin
        bus.PC_read   = 1'b1;
        bus.MAR_write = 1'b1;
      end
      StRead: begin
        bus.MAR_mem_read = 1'b1;
        bus.MEM_RW       = 1'b1;
        bus.MEM_EN       = 1'b1;
      end
      StWait: begin
        bus.MEM_RW = 1'b1;
        bus.MEM_EN = 1'b1;
      end
      StLatch: bus.MDR_mem_write = 1'b1;
      StLoad: begin
        bus.MDR_read         = 1'b1;
        bus.IR_write[idx_q]  = 1'b1;
        bus.PC_increment     = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      StErr:   bus.err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Randomised scoreboard bench for fetch_seq: a transaction-level model builds the expected
// per-cycle strobe trace; a negedge monitor pops and compares it against the DUT.
module tb_fetch_seq;

  localparam int unsigned W      = 2;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WMAX   = 4;
  localparam int          OW     = 11 + W;

  typedef logic [OW-1:0] ovec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_seq_if #(.WORDS(W)) bus ();

  fetch_seq #(
    .WORDS    (W),
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ovec_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  ovec_t got;

  assign got = {bus.PC_read, bus.MAR_write, bus.MAR_mem_read, bus.MEM_RW, bus.MEM_EN,
                bus.MDR_mem_write, bus.MDR_read, bus.IR_write, bus.PC_increment,
                bus.busy, bus.done, bus.err};

  function automatic ovec_t pack(input bit pr, input bit mw, input bit mmr, input bit rw,
                                 input bit en, input bit mdw, input bit mdr,
                                 input logic [W-1:0] ir, input bit inc, input bit bsy,
                                 input bit dn, input bit er);
    return {pr, mw, mmr, rw, en, mdw, mdr, ir, inc, bsy, dn, er};
  endfunction

  function automatic ovec_t v_addr();
    return pack(1, 1, 0, 0, 0, 0, 0, '0, 0, 1, 0, 0);
  endfunction
  function automatic ovec_t v_read();
    return pack(0, 0, 1, 1, 1, 0, 0, '0, 0, 1, 0, 0);
  endfunction
  function automatic ovec_t v_wait();
    return pack(0, 0, 0, 1, 1, 0, 0, '0, 0, 1, 0, 0);
  endfunction
  function automatic ovec_t v_latch();
    return pack(0, 0, 0, 0, 0, 1, 0, '0, 0, 1, 0, 0);
  endfunction
  function automatic ovec_t v_load(input int w);
    logic [W-1:0] ir;
    ir    = '0;
    ir[w] = 1'b1;
    return pack(0, 0, 0, 0, 0, 0, 1, ir, 1, 1, 0, 0);
  endfunction
  function automatic ovec_t v_done();
    return pack(0, 0, 0, 0, 0, 0, 0, '0, 0, 1, 1, 0);
  endfunction
  function automatic ovec_t v_err();
    return pack(0, 0, 0, 0, 0, 0, 0, '0, 0, 1, 0, 1);
  endfunction

  // Monitor: an empty queue means the DUT must be quiet.
  always @(negedge clk) begin
    ovec_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL strobes t=%0t got=%b required=%b", $time, got, e);
    end
  end

  task automatic step(input bit st, input bit ab, input bit mf, input ovec_t e);
    @(posedge clk);
    #1;
    bus.start = st;
    bus.abort = ab;
    bus.MFC   = mf;
    exp_q.push_back(e);
  endtask

  task automatic direct_check(input string name, input ovec_t e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%b required=%b", name, $time, got, e);
    end
  endtask

  // dly[w] = WAIT cycles with MFC low before MFC rises for word w; abort_at indexes the trace
  // (cycle after the start cycle is 0), -1 for none.
  task automatic run_txn(input int dly[W], input int abort_at);
    ovec_t tr[$];
    bit    mf[$];
    bit    timed_out;
    int    n;
    timed_out = 0;
    for (int w = 0; w < W; w++) begin
      tr.push_back(v_addr());
      mf.push_back(1'($urandom % 2));
      tr.push_back(v_read());
      mf.push_back(1'($urandom % 2));
      for (int c = 0; c <= dly[w]; c++) begin
        tr.push_back(v_wait());
        if (c == dly[w]) begin
          mf.push_back(1'b1);
        end else begin
          mf.push_back(1'b0);
          if (WMAX != 0 && c == int'(WMAX) - 1) begin
            timed_out = 1;
            break;
          end
        end
      end
      if (timed_out) begin
        tr.push_back(v_err());
        mf.push_back(1'($urandom % 2));
        break;
      end
      tr.push_back(v_latch());
      mf.push_back(1'($urandom % 2));
      tr.push_back(v_load(w));
      mf.push_back(1'($urandom % 2));
    end
    if (!timed_out) begin
      tr.push_back(v_done());
      mf.push_back(1'($urandom % 2));
    end
    n = tr.size();
    if (abort_at >= 0 && abort_at < n) n = abort_at + 1;
    step(1'b1, 1'($urandom % 2), 1'($urandom % 2), '0);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom % 2), (abort_at == i), mf[i], tr[i]);
    end
  endtask

  task automatic gap();
    int g;
    g = $urandom % 3;
    for (int i = 0; i < g; i++) step(1'b0, 1'($urandom % 2), 1'($urandom % 2), '0);
  endtask

  task automatic reset_mid_load();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, v_addr());
    step(1'b0, 1'b0, 1'b0, v_read());
    step(1'b0, 1'b0, 1'b1, v_wait());
    step(1'b0, 1'b0, 1'b0, v_latch());
    @(posedge clk);
    #1;
    direct_check("pre_reset_load", v_load(0));
    #1;
    reset = 1'b0;
    #1;
    direct_check("async_reset_clear", '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
  endtask

  initial begin
    int d[W];
    int ab;
    int r;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.MFC   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);

    d = '{0, 0};  run_txn(d, -1);  gap();
    d = '{9, 0};  run_txn(d, -1);  gap();
    d = '{3, 3};  run_txn(d, -1);  gap();
    d = '{0, 2};  run_txn(d, 7);
    d = '{0, 0};  run_txn(d, -1);
    d = '{1, 0};  run_txn(d, -1);
    reset_mid_load();
    d = '{0, 1};  run_txn(d, -1);  gap();

    for (int t = 0; t < 80; t++) begin
      for (int w = 0; w < W; w++) begin
        r = $urandom % 10;
        if (r < 4)       d[w] = 0;
        else if (r < 7)  d[w] = 1 + ($urandom % 2);
        else if (r == 7) d[w] = WMAX - 1;
        else if (r == 8) d[w] = WMAX;
        else             d[w] = WMAX + 2;
      end
      ab = (($urandom % 4) == 0) ? int'($urandom % 14) : -1;
      run_txn(d, ab);
      gap();
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
